// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - RV32M multiply/divide unit for the EX stage.
// MULDIV_FAST_MUL_EN: single-cycle multiply instead of the 32-step shift-add path.
`timescale 1ns/1ps
module ex_muldiv_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rs1_value_i,
    input  logic [31:0] rs2_value_i,
    input  logic [4:0]  rd_i,
    input  logic        flush_i,
    input  logic        stall_i,
    output logic        busywait_o,
    output logic [31:0] result_o,
    output logic        result_valid_o,
    output logic [4:0]  rd_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] opb_q, opb_d;
    logic        neg_a_q, neg_a_d;
    logic        neg_b_q, neg_b_d;
    logic [31:0] result_q, result_d;

    logic        a_signed_in, b_signed_in, neg_a_in, neg_b_in;
    logic [31:0] mag_a_in, mag_b_in;
    logic        div_zero_in, div_ovf_in;
    logic [31:0] special_res;
    logic        fast_take;
    logic [31:0] fast_res;

    // Operand decode: magnitudes and sign flags for the accept cycle
    always_comb begin
        a_signed_in = (funct3_i == 3'd1) || (funct3_i == 3'd2) ||
                      (funct3_i == 3'd4) || (funct3_i == 3'd6);
        b_signed_in = (funct3_i == 3'd1) || (funct3_i == 3'd4) || (funct3_i == 3'd6);
        neg_a_in    = a_signed_in && rs1_value_i[31];
        neg_b_in    = b_signed_in && rs2_value_i[31];
        mag_a_in    = neg_a_in ? (32'd0 - rs1_value_i) : rs1_value_i;
        mag_b_in    = neg_b_in ? (32'd0 - rs2_value_i) : rs2_value_i;
        div_zero_in = funct3_i[2] && (rs2_value_i == 32'd0);
        div_ovf_in  = funct3_i[2] && !funct3_i[0] &&
                      (rs1_value_i == 32'h8000_0000) && (rs2_value_i == 32'hFFFF_FFFF);
        if (div_zero_in)
            special_res = funct3_i[1] ? rs1_value_i : 32'hFFFF_FFFF;
        else
            special_res = funct3_i[1] ? 32'd0 : 32'h8000_0000;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] fast_prod, fast_prod_s;
    always_comb begin
        fast_prod   = {32'd0, mag_a_in} * {32'd0, mag_b_in};
        fast_prod_s = (neg_a_in ^ neg_b_in) ? (64'd0 - fast_prod) : fast_prod;
        fast_take   = !funct3_i[2];
        fast_res    = (funct3_i == 3'd0) ? fast_prod_s[31:0] : fast_prod_s[63:32];
    end
`else
    always_comb begin
        fast_take = 1'b0;
        fast_res  = 32'd0;
    end
`endif

    logic [32:0] mul_sum, div_shift, div_trial;
    logic [31:0] step_acc, step_lo;
    logic [63:0] prod, prod_s;
    logic [31:0] quo_s, rem_s, final_res;

    // One iteration: restoring divide (acc = remainder, lo = dividend/quotient)
    // or shift-add multiply (acc = product high, lo = multiplier/product low)
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : 33'd0);
        div_shift = {acc_q, lo_q[31]};
        div_trial = div_shift - {1'b0, opb_q};
        if (op_q[2]) begin
            if (!div_trial[32]) begin
                step_acc = div_trial[31:0];
                step_lo  = {lo_q[30:0], 1'b1};
            end else begin
                step_acc = div_shift[31:0];
                step_lo  = {lo_q[30:0], 1'b0};
            end
        end else begin
            step_acc = mul_sum[32:1];
            step_lo  = {mul_sum[0], lo_q[31:1]};
        end
        prod   = {step_acc, step_lo};
        prod_s = (neg_a_q ^ neg_b_q) ? (64'd0 - prod) : prod;
        quo_s  = (neg_a_q ^ neg_b_q) ? (32'd0 - step_lo) : step_lo;
        rem_s  = neg_a_q ? (32'd0 - step_acc) : step_acc;
        if (op_q[2])
            final_res = op_q[1] ? rem_s : quo_s;
        else
            final_res = (op_q == 3'd0) ? prod_s[31:0] : prod_s[63:32];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        rd_d       = rd_q;
        acc_d      = acc_q;
        lo_d       = lo_q;
        opb_d      = opb_q;
        neg_a_d    = neg_a_q;
        neg_b_d    = neg_b_q;
        result_d   = result_q;
        busywait_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_i && !flush_i) begin
                    busywait_o = 1'b1;
                    op_d       = funct3_i;
                    rd_d       = rd_i;
                    neg_a_d    = neg_a_in;
                    neg_b_d    = neg_b_in;
                    cnt_d      = 5'd0;
                    acc_d      = 32'd0;
                    lo_d       = funct3_i[2] ? mag_a_in : mag_b_in;
                    opb_d      = funct3_i[2] ? mag_b_in : mag_a_in;
                    if (div_zero_in || div_ovf_in) begin
                        result_d = special_res;
                        state_d  = DONE;
                    end else if (fast_take) begin
                        result_d = fast_res;
                        state_d  = DONE;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                busywait_o = 1'b1;
                acc_d      = step_acc;
                lo_d       = step_lo;
                cnt_d      = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    result_d = final_res;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (!stall_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A flush abandons whatever is in flight; the result register is never consumed
        if (flush_i)
            state_d = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            op_q     <= 3'd0;
            rd_q     <= 5'd0;
            acc_q    <= 32'd0;
            lo_q     <= 32'd0;
            opb_q    <= 32'd0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            result_q <= result_d;
        end
    end

    assign result_o       = result_q;
    assign rd_o           = rd_q;
    assign result_valid_o = (state_q == DONE);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - Scoreboard bench for ex_muldiv_unit with a behavioural RV32M model.
`timescale 1ns/1ps
module tb_ex_muldiv_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic [2:0]  funct3_i = 3'd0;
    logic [31:0] rs1_value_i = 32'd0;
    logic [31:0] rs2_value_i = 32'd0;
    logic [4:0]  rd_i = 5'd0;
    logic        flush_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        busywait_o;
    logic [31:0] result_o;
    logic        result_valid_o;
    logic [4:0]  rd_o;

    always #5 clk_i = ~clk_i;

    ex_muldiv_unit dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .valid_i        (valid_i),
        .funct3_i       (funct3_i),
        .rs1_value_i    (rs1_value_i),
        .rs2_value_i    (rs2_value_i),
        .rd_i           (rd_i),
        .flush_i        (flush_i),
        .stall_i        (stall_i),
        .busywait_o     (busywait_o),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .rd_o           (rd_o)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
        end
    endtask

    // RV32M semantics from plain 64-bit arithmetic
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        longint      sa, sb, q, r;
        logic        as, bs;
        if (!f3[2]) begin
            as = (f3 == 3'd1) || (f3 == 3'd2);
            bs = (f3 == 3'd1);
            ea = as ? {{32{a[31]}}, a} : {32'd0, a};
            eb = bs ? {{32{b[31]}}, b} : {32'd0, b};
            p  = ea * eb;
            return (f3 == 3'd0) ? p[31:0] : p[63:32];
        end
        if (b == 32'd0)
            return f3[1] ? a : 32'hFFFF_FFFF;
        as = !f3[0];
        sa = as ? longint'($signed(a)) : longint'({32'd0, a});
        sb = as ? longint'($signed(b)) : longint'({32'd0, b});
        q  = sa / sb;
        r  = sa % sb;
        return f3[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic int exp_bw(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && b == 32'd0) return 1;
        if (f3[2] && !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!f3[2]) return 1;
`endif
        return 33;
    endfunction

    // Monitor: one result is consumed per DONE, on the cycle it is released
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            #2;
            if (result_valid_o && !stall_i) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got result %08h want none", result_o);
                end else begin
                    e = expq.pop_front();
                    chk("result", result_o, e.res);
                    chk("rd", {27'd0, rd_o}, {27'd0, e.rd});
                end
            end
        end
    end

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int stall_n);
        int   bw;
        int   guard;
        exp_t e;
        @(negedge clk_i);
        valid_i     = 1'b1;
        funct3_i    = f3;
        rs1_value_i = a;
        rs2_value_i = b;
        rd_i        = rd;
        e.res = model(f3, a, b);
        e.rd  = rd;
        expq.push_back(e);
        #1;
        bw = busywait_o ? 1 : 0;
        @(negedge clk_i);
        valid_i = 1'b0;
        stall_i = (stall_n > 0);
        #1;
        guard = 0;
        while (busywait_o && guard < 100) begin
            bw++;
            guard++;
            @(negedge clk_i);
            #1;
        end
        chk("busywait_cycles", bw, exp_bw(f3, a, b));
        chk("done_reached", {31'd0, result_valid_o}, 32'd1);
        for (int i = 0; i < stall_n; i++) begin
            chk("stall_hold_valid", {31'd0, result_valid_o}, 32'd1);
            chk("stall_hold_result", result_o, e.res);
            chk("stall_hold_rd", {27'd0, rd_o}, {27'd0, rd});
            @(negedge clk_i);
            if (i == stall_n - 1) stall_i = 1'b0;
            #1;
        end
        if (stall_n > 0) begin
            @(negedge clk_i);
            #1;
            chk("idle_after_stall", {31'd0, result_valid_o}, 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b;
        int          sel;

        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("reset_result", result_o, 32'd0);
        chk("reset_rd", {27'd0, rd_o}, 32'd0);
        chk("reset_valid", {31'd0, result_valid_o}, 32'd0);
        chk("reset_busywait", {31'd0, busywait_o}, 32'd0);

        // flush beats valid in IDLE
        @(negedge clk_i);
        valid_i = 1'b1; funct3_i = 3'd4; rs1_value_i = 32'd9; rs2_value_i = 32'd2;
        flush_i = 1'b1;
        #1;
        chk("flush_prio_busywait", {31'd0, busywait_o}, 32'd0);
        @(negedge clk_i);
        valid_i = 1'b0; flush_i = 1'b0;
        #1;
        chk("flush_prio_valid", {31'd0, result_valid_o}, 32'd0);

        issue(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd5, 0);
        issue(3'd6, 32'hFFFF_FFEC, 32'd3, 5'd6, 0);
        issue(3'd5, 32'd100, 32'd0, 5'd7, 0);
        issue(3'd7, 32'd100, 32'd0, 5'd8, 0);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd9, 0);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);
        issue(3'd5, 32'd7, 32'd2, 5'd12, 5);

        // flush at CALC cycle 10
        @(negedge clk_i);
        valid_i = 1'b1; funct3_i = 3'd4; rs1_value_i = 32'd1000; rs2_value_i = 32'd7; rd_i = 5'd13;
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (9) @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        #1;
        chk("flush_busywait", {31'd0, busywait_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("flush_no_result", {31'd0, result_valid_o}, 32'd0);
            @(negedge clk_i);
            #1;
        end

        // reset at CALC cycle 20
        @(negedge clk_i);
        valid_i = 1'b1; funct3_i = 3'd4; rs1_value_i = 32'd12345; rs2_value_i = 32'd11; rd_i = 5'd14;
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (19) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("rst_result", result_o, 32'd0);
        chk("rst_rd", {27'd0, rd_o}, 32'd0);
        chk("rst_valid", {31'd0, result_valid_o}, 32'd0);
        chk("rst_busywait", {31'd0, busywait_o}, 32'd0);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, 0);

        for (int n = 0; n < 40; n++) begin
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0)       b = 32'd0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2)  b = 32'($urandom_range(1, 15));
            else if (sel == 3)  b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            else                b = $urandom;
            issue(f3, a, b, 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end

        repeat (3) @(negedge clk_i);
        chk("queue_empty", expq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
